// File: rtl/sobol_rng_gen.sv
// ---------------------------------------------------------------------------
// sobol_rng_gen
//   Single-dimension Sobol sequence generator. A step counter advances once
//   per enabled cycle; the position of its lowest zero bit selects one of
//   BITWIDTH direction vectors, which is XORed into the output register.
//   Direction vectors are loadable at runtime so any Sobol dimension can be
//   selected; after reset they hold the van der Corput defaults.
//
// Ports
//   clk       in   1            clock, all state updates on the rising edge
//   rst       in   1            synchronous active-high reset
//   clr       in   1            synchronous restart (direction vectors kept)
//   enable    in   1            advance one Sobol step this cycle
//   dvWrEn    in   1            direction-vector write strobe
//   dvWrAddr  in   LOGBITWIDTH  direction-vector index to write
//   dvWrData  in   BITWIDTH     direction-vector value
//   sobolSeq  out  BITWIDTH     current Sobol value (registered)
//   lszIdx    out  LOGBITWIDTH  index used by the most recent step
//   valid     out  1            one-cycle pulse: sobolSeq updated this cycle
//   wrap      out  1            one-cycle pulse: period completed, back at 0
//
// Handshake: there is no back-pressure. valid is high for exactly the cycle
// in which sobolSeq/lszIdx/wrap carry the result of a step; a consumer must
// take the value in that cycle. When valid is low, sobolSeq holds its value
// (except after rst/clr, where it returns to 0).
// ---------------------------------------------------------------------------
module sobol_rng_gen #(
  parameter int BITWIDTH    = 8,
  parameter int LOGBITWIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   enable,
  input  logic                   dvWrEn,
  input  logic [LOGBITWIDTH-1:0] dvWrAddr,
  input  logic [BITWIDTH-1:0]    dvWrData,
  output logic [BITWIDTH-1:0]    sobolSeq,
  output logic [LOGBITWIDTH-1:0] lszIdx,
  output logic                   valid,
  output logic                   wrap
);

  logic [BITWIDTH-1:0]    cnt;
  logic [BITWIDTH-1:0]    dv [BITWIDTH];
  logic [LOGBITWIDTH-1:0] lszComb;
  logic                   cntAllOnes;

  // Lowest zero bit of cnt. Scanning from the top down lets the lowest zero
  // win. When cnt is all ones no zero exists and the default BITWIDTH-1 is
  // exactly the index the terminal step reports.
  always_comb begin
    lszComb = LOGBITWIDTH'(BITWIDTH - 1);
    for (int i = BITWIDTH - 1; i >= 0; i--) begin
      if (!cnt[i]) lszComb = LOGBITWIDTH'(i);
    end
  end

  assign cntAllOnes = &cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sobolSeq <= '0;
      lszIdx   <= '0;
      valid    <= 1'b0;
      wrap     <= 1'b0;
      for (int k = 0; k < BITWIDTH; k++) begin
        dv[k] <= BITWIDTH'(1) << (BITWIDTH - 1 - k);
      end
    end else begin
      if (clr) begin
        // Restart; a concurrent enable is dropped. lszIdx keeps its value.
        cnt      <= '0;
        sobolSeq <= '0;
        valid    <= 1'b0;
        wrap     <= 1'b0;
      end else if (enable) begin
        valid  <= 1'b1;
        lszIdx <= lszComb;
        if (cntAllOnes) begin
          // Last step of the period returns the sequence to its origin.
          cnt      <= '0;
          sobolSeq <= '0;
          wrap     <= 1'b1;
        end else begin
          cnt      <= cnt + 1'b1;
          // dv read here is the pre-edge value, so a same-cycle write to the
          // selected index only affects later steps.
          sobolSeq <= sobolSeq ^ dv[lszComb];
          wrap     <= 1'b0;
        end
      end else begin
        valid <= 1'b0;
        wrap  <= 1'b0;
      end

      if (dvWrEn) begin
        dv[dvWrAddr] <= dvWrData;
      end
    end
  end

endmodule

// File: tb/tb_sobol_rng_gen.sv
// ---------------------------------------------------------------------------
// tb_sobol_rng_gen
//   Self-checking bench for sobol_rng_gen (BITWIDTH=8). The driver updates a
//   behavioural model on every issued cycle and pushes the expected step
//   result into exp_q; an independent monitor pops and compares whenever the
//   DUT raises valid, and checks that outputs hold otherwise.
// ---------------------------------------------------------------------------
module tb_sobol_rng_gen;

  localparam int W  = 8;
  localparam int LW = 3;

  // clock / reset ----------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          enable = 1'b0;
  logic          dv_wr_en = 1'b0;
  logic [LW-1:0] dv_wr_addr = '0;
  logic [W-1:0]  dv_wr_data = '0;
  logic [W-1:0]  sobol_seq;
  logic [LW-1:0] lsz_idx;
  logic          valid;
  logic          wrap;

  sobol_rng_gen #(.BITWIDTH(W), .LOGBITWIDTH(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .enable   (enable),
    .dvWrEn   (dv_wr_en),
    .dvWrAddr (dv_wr_addr),
    .dvWrData (dv_wr_data),
    .sobolSeq (sobol_seq),
    .lszIdx   (lsz_idx),
    .valid    (valid),
    .wrap     (wrap)
  );

  // scoreboard state -------------------------------------------------------
  int checks = 0;
  int errors = 0;

  // expected entry: {wrap, lszIdx, sobolSeq}
  logic [W+LW:0] exp_q[$];
  logic [W-1:0]  exp_hold = '0;
  bit            mon_on = 1'b0;
  int            seen [256];
  int            wrap_count = 0;

  // behavioural model
  logic [W-1:0] m_dv [W];
  int           m_cnt = 0;
  logic [W-1:0] m_x = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest zero bit of c via arithmetic: (c+1) & ~c isolates it as a power of two.
  function automatic int model_lsz(input int c);
    return $clog2(((c + 1) & ~c) & 255);
  endfunction

  // driver -----------------------------------------------------------------
  task automatic cyc(input logic en, input logic c, input logic r,
                     input logic we, input logic [LW-1:0] a, input logic [W-1:0] d);
    int idx;
    @(negedge clk);
    enable = en; clr = c; rst = r;
    dv_wr_en = we; dv_wr_addr = a; dv_wr_data = d;
    if (r) begin
      for (int k = 0; k < W; k++) m_dv[k] = 8'h80 >> k;
      m_cnt = 0; m_x = '0; exp_hold = '0;
    end else begin
      if (c) begin
        m_cnt = 0; m_x = '0; exp_hold = '0;
      end else if (en) begin
        if (m_cnt == 255) begin
          m_cnt = 0; m_x = '0;
          exp_q.push_back({1'b1, LW'(W - 1), W'(0)});
        end else begin
          idx = model_lsz(m_cnt);
          m_x = m_x ^ m_dv[idx];
          m_cnt = m_cnt + 1;
          exp_q.push_back({1'b0, LW'(idx), m_x});
        end
      end
      if (we) m_dv[a] = d;
    end
  endtask

  task automatic step(); cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0); endtask
  task automatic idle(); cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0); endtask
  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    mon_on = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
  endtask
  // wait until the result of the last issued cycle is visible
  task automatic settle(); @(posedge clk); #2; endtask

  // monitor ----------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          logic [W+LW:0] e;
          e = exp_q.pop_front();
          chk("step_result", int'({wrap, lsz_idx, sobol_seq}), int'(e));
          exp_hold = e[W-1:0];
          seen[sobol_seq]++;
          if (wrap) wrap_count++;
        end
      end else begin
        chk("hold_seq", int'(sobol_seq), int'(exp_hold));
        chk("hold_wrap", int'(wrap), 0);
        if (exp_q.size() != 0) begin
          chk("missing_valid", exp_q.size(), 0);
          exp_q.delete();
        end
      end
    end
  end

  // stimulus ---------------------------------------------------------------
  initial begin
    int bad;
    // reset and default state
    do_reset();
    idle();
    settle();
    chk("rst_seq", int'(sobol_seq), 0);
    chk("rst_lsz", int'(lsz_idx), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_wrap", int'(wrap), 0);

    // full period from reset
    for (int i = 0; i < 256; i++) seen[i] = 0;
    wrap_count = 0;
    step();
    settle();
    chk("dv0_default", int'(sobol_seq), 8'h80);
    chk("first_valid", int'(valid), 1);
    for (int n = 2; n <= 128; n++) step();
    settle();
    // x_128 = dv[7]^dv[6] with defaults, step used index 7
    chk("dv7_default_seq", int'(sobol_seq), 8'h03);
    chk("dv7_default_lsz", int'(lsz_idx), 7);
    for (int n = 129; n <= 256; n++) step();
    settle();
    chk("period_end_seq", int'(sobol_seq), 0);
    chk("period_end_wrap", int'(wrap), 1);
    chk("period_end_lsz", int'(lsz_idx), W - 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (seen[i] != 1) bad++;
    chk("period_unique", bad, 0);
    chk("wrap_once", wrap_count, 1);
    step();
    settle();
    chk("after_wrap_seq", int'(sobol_seq), 8'h80);
    chk("after_wrap_wrap", int'(wrap), 0);

    // random enable gaps, default vectors
    do_reset();
    for (int i = 0; i < 150; i++) cyc($urandom_range(0, 2) != 0, 1'b0, 1'b0, 1'b0, '0, '0);

    // direction-vector write colliding with a step that uses the same index
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h55);
    settle();
    chk("collision_old_dv", int'(sobol_seq), 8'h80);
    step();
    step();
    settle();
    chk("collision_new_dv", int'(sobol_seq), 8'h95);

    // clr with concurrent enable, written vector retained
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'hAA);
    for (int i = 0; i < 5; i++) step();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    settle();
    chk("clr_seq", int'(sobol_seq), 0);
    chk("clr_valid", int'(valid), 0);
    step();
    settle();
    chk("clr_next_dv0", int'(sobol_seq), 8'h80);
    for (int i = 0; i < 7; i++) step();
    settle();
    // x_8 = dv[3]^dv[2] = 0xAA^0x20
    chk("clr_dv3_kept", int'(sobol_seq), 8'h8A);

    // reset mid-operation with a write that must be dropped
    for (int i = 0; i < 3; i++) step();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h11);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h11);
    step();
    settle();
    chk("rst_drops_write", int'(sobol_seq), 8'h80);

    // mixed random traffic: enables, writes, occasional clr
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 1'b0,
          $urandom_range(0, 7) == 0, LW'($urandom_range(0, W - 1)), W'($urandom_range(0, 255)));
    end

    idle();
    idle();
    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
